// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges 1-cycle ALU results and FIFO-buffered load returns onto
// the single register-file write port, and tracks registers with loads in flight.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_W-1:0]             ld_rd,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          issue_set,
    input  logic [ADDR_W-1:0]             issue_rd,
    output logic [ADDR_W-1:0]             RdAddr,
    output logic [DATA_W-1:0]             RdData,
    output logic                          RegWrite,
    output logic [2**ADDR_W-1:0]          pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    logic [ADDR_W-1:0] r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [NREG-1:0]   r_pend;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_alu_xfer;
    logic              w_sel;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_pend_next;

    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign ld_ready   = ~w_full;
    assign alu_ready  = ~w_full & ~(r_pend[alu_rd] & (alu_rd != '0));
    assign w_push     = ld_valid & ~w_full;
    assign w_alu_xfer = alu_valid & alu_ready;
    // A full FIFO always drains; otherwise the ALU has priority over buffered loads.
    assign w_pop      = w_full | (~w_alu_xfer & ~w_empty);

    always_comb begin
        w_sel      = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (w_pop) begin
            w_sel      = 1'b1;
            w_sel_rd   = r_fifo_rd[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end else if (w_alu_xfer) begin
            w_sel      = 1'b1;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end
    end

    // Per-register scoreboard; a new issue beats the retirement of an older load.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_r0
                assign w_pend_next[gi] = 1'b0;
            end else begin : g_rn
                assign w_pend_next[gi] = (issue_set & (issue_rd == ADDR_W'(gi))) |
                                         (r_pend[gi] & ~(w_pop & (w_sel_rd == ADDR_W'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= ld_rd;
            r_fifo_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pend      <= '0;
            r_reg_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_pend  <= w_pend_next;
            if (w_sel) begin
                r_rd_addr   <= w_sel_rd;
                r_rd_data   <= w_sel_data;
                r_reg_write <= (w_sel_rd != '0);
            end else begin
                r_reg_write <= 1'b0;
            end
        end
    end

    assign RdAddr     = r_rd_addr;
    assign RdData     = r_rd_data;
    assign RegWrite   = r_reg_write;
    assign pend_mask  = r_pend;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized check of wb_arbiter against a queue-based model of the
// write-back rules (FIFO order, priority, scoreboard).
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_set;
    logic [4:0]  issue_rd;
    logic [4:0]  RdAddr;
    logic [31:0] RdData;
    logic        RegWrite;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_set(issue_set), .issue_rd(issue_rd),
        .RdAddr(RdAddr), .RdData(RdData), .RegWrite(RegWrite),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          verbose  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_pend = '0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Called at posedge+1; drives one cycle of inputs and checks readies and results.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                         input logic is, input logic [4:0] ird);
        bit   full, e_ld_rdy, e_alu_rdy, popped;
        ent_t e;
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        ld_valid  = lv;  ld_rd  = lrd;  ld_data  = ldd;
        issue_set = is;  issue_rd = ird;
        #2;
        full      = (m_q.size() == 4);
        e_ld_rdy  = !full;
        e_alu_rdy = !full && !(m_pend[ard] && ard != 0);
        chk("ld_ready", ld_ready, e_ld_rdy);
        chk("alu_ready", alu_ready, e_alu_rdy);
        @(posedge clk);
        popped = 0;
        e = '0;
        if (full || (!(av && e_alu_rdy) && m_q.size() != 0)) begin
            e = m_q.pop_front();
            popped = 1;
            m_addr = e.rd; m_data = e.data; m_we = (e.rd != 0);
        end else if (av && e_alu_rdy) begin
            m_addr = ard; m_data = ad; m_we = (ard != 0);
        end else begin
            m_we = 1'b0;
        end
        if (lv && e_ld_rdy) begin
            ent_t n;
            n.rd = lrd; n.data = ldd;
            m_q.push_back(n);
        end
        if (popped && e.rd != 0) m_pend[e.rd] = 1'b0;
        if (is && ird != 0)      m_pend[ird]  = 1'b1;
        #1;
        chk("RegWrite", RegWrite, m_we);
        chk("RdAddr", RdAddr, m_addr);
        chk("RdData", RdData, m_data);
        chk("pend_mask", pend_mask, m_pend);
        chk("fifo_count", fifo_count, m_q.size());
        if (verbose)
            $display("t=%0t we=%0b rd=%0d data=%h cnt=%0d pend=%h",
                     $time, RegWrite, RdAddr, RdData, fifo_count, pend_mask);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        alu_valid = 0; ld_valid = 0; issue_set = 0;
        alu_rd = 0; alu_data = 0; ld_rd = 0; ld_data = 0; issue_rd = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_RdAddr", RdAddr, 0);
        chk("rst_RdData", RdData, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_pend_mask", pend_mask, 0);
        chk("rst_ld_ready", ld_ready, 1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        alu_valid = 0; ld_valid = 0; issue_set = 0;
        alu_rd = 0; alu_data = 0; ld_rd = 0; ld_data = 0; issue_rd = 0;
        model_clear();
        #1;
        do_reset();
        verbose = 1'b1;

        // ALU path, including a discarded write to R0
        cycle(1, 5, 32'h0000_1234, 0, 0, 0, 0, 0);
        chk("t2_we", RegWrite, 1);
        chk("t2_addr", RdAddr, 5);
        chk("t2_data", RdData, 32'h0000_1234);
        cycle(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("t2_r0_we", RegWrite, 0);

        // ALU outranks buffered loads; loads follow in arrival order
        cycle(1, 10, 32'hA10, 1, 3, 32'h333, 0, 0);
        cycle(1, 11, 32'hA11, 1, 4, 32'h444, 0, 0);
        cycle(1, 12, 32'hA12, 0, 0, 0, 0, 0);
        idle();
        chk("t3_first_load", RdAddr, 3);
        idle();
        chk("t3_second_load", RdAddr, 4);
        idle();

        // FIFO full stalls the ALU and forces a drain
        for (int i = 0; i < 4; i++)
            cycle(1, 13, 32'hC0 + i, 1, 5'(20 + i), 32'hF0 + i, 0, 0);
        chk("t4_count_full", fifo_count, 4);
        chk("t4_alu_stalled", alu_ready, 0);
        for (int i = 0; i < 8; i++) cycle(1, 13, 32'hD0 + i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle();

        // Interlock on a pending load destination
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        chk("t5_pend_set", pend_mask[7], 1);
        for (int i = 0; i < 3; i++) cycle(1, 7, 32'hAAAA, 0, 0, 0, 0, 0);
        cycle(1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 0, 0);
        cycle(1, 7, 32'hAAAA, 0, 0, 0, 0, 0);
        chk("t5_load_data", RdData, 32'hBBBB);
        chk("t5_pend_clr", pend_mask[7], 0);
        cycle(1, 7, 32'hAAAA, 0, 0, 0, 0, 0);
        chk("t5_alu_data", RdData, 32'hAAAA);
        idle();

        // Set wins over clear on the same edge
        cycle(0, 0, 0, 0, 0, 0, 1, 9);
        cycle(0, 0, 0, 1, 9, 32'h9999, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 9);
        chk("t6_we", RegWrite, 1);
        chk("t6_addr", RdAddr, 9);
        chk("t6_pend_kept", pend_mask[9], 1);
        verbose = 1'b0;

        // Randomized traffic with a small register set to provoke collisions
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 99) < 50, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 99) < 25, 5'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 6; i++) idle();

        // Reset with three loads queued and a pending register
        verbose = 1'b1;
        cycle(1, 1, 32'h11, 1, 2, 32'h22, 1, 2);
        cycle(1, 1, 32'h12, 1, 3, 32'h33, 0, 0);
        cycle(1, 1, 32'h13, 1, 4, 32'h44, 0, 0);
        chk("t1_queued", fifo_count, 3);
        do_reset();
        idle();
        cycle(1, 6, 32'h66, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
